// File: rtl/fir_decim_out.sv
// FIR output stage: discards the start-up transient, decimates, rounds and
// saturates kept samples, then queues them in a small FIFO behind valid/ready.
module fir_decim_out #(
  parameter int unsigned IN_W   = 19,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 3,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned WARMUP = 33,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [IN_W-1:0]          In_Data,
  input  logic                     In_Valid,
  output logic [OUT_W-1:0]         Out_Data,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic                     Sat_Flag,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WC_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned R_W   = IN_W + 1 - SHIFT;

  localparam logic [IN_W:0]    RND_ADD = (IN_W+1)'(2 ** (SHIFT - 1));
  localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

  logic [WC_W-1:0]  warm_q,  warm_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;

  logic             warm_done;
  logic             keep;
  logic [IN_W:0]    rnd_sum;
  logic [R_W-1:0]   rnd_shr;
  logic             clamp;
  logic [OUT_W-1:0] rounded;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign warm_done  = (warm_q == WC_W'(WARMUP));
  assign keep       = In_Valid && warm_done && (phase_q == '0);

  // Round half toward +inf, then clamp whenever the shifted value needs more than OUT_W bits
  assign rnd_sum    = {In_Data[IN_W-1], In_Data} + RND_ADD;
  assign rnd_shr    = R_W'(rnd_sum >> SHIFT);
  assign clamp      = (rnd_shr[R_W-1] != rnd_shr[R_W-2]);
  assign rounded    = clamp ? (rnd_shr[R_W-1] ? MIN_OUT : MAX_OUT) : rnd_shr[OUT_W-1:0];

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && Out_Ready;
  assign push_ok    = keep && (!fifo_full || pop);
  assign drop       = keep && fifo_full && !pop;

  always_comb begin
    warm_d   = warm_q;
    phase_d  = phase_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sat_d    = sat_q | (keep & clamp);
    ovf_d    = ovf_q | drop;

    if (In_Valid && !warm_done) begin
      warm_d = warm_q + WC_W'(1);
    end else if (In_Valid) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = rounded;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    // Head register tracks the post-edge FIFO state so Out_Data stays registered
    out_data_d  = mem_d[rd_ptr_d];
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      warm_q      <= '0;
      phase_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      warm_q      <= warm_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
  assign Sat_Flag  = sat_q;
  assign Overflow  = ovf_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: directed scenarios plus a randomized run checked
// against a queue-based reference model of the output stage.
module tb_fir_decim_out;

  localparam int IN_W   = 19;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 3;
  localparam int DECIM  = 4;
  localparam int WARMUP = 33;
  localparam int DEPTH  = 4;

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic [IN_W-1:0] In_Data = '0;
  logic            In_Valid = 1'b0;
  logic            Out_Ready = 1'b0;
  logic [OUT_W-1:0] Out_Data;
  logic            Out_Valid;
  logic            Sat_Flag;
  logic            Overflow;
  logic [2:0]      Count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int m_warm;
  int m_phase;
  bit m_sat;
  bit m_ovf;
  int mq[$];

  always #5 clk = ~clk;

  fir_decim_out #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
    .DECIM(DECIM), .WARMUP(WARMUP), .DEPTH(DEPTH)
  ) dut (
    .Clk(clk), .Reset(Reset), .In_Data(In_Data), .In_Valid(In_Valid),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Sat_Flag(Sat_Flag), .Overflow(Overflow), .Count(Count)
  );

  function automatic int ref_round(input int x, output bit s);
    int r;
    r = (x + (1 << (SHIFT - 1))) >>> SHIFT;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    return r;
  endfunction

  function automatic int rand_sample();
    logic [IN_W-1:0] r;
    r = IN_W'($urandom);
    return int'($signed(r));
  endfunction

  // One clock: drive inputs, advance model on the edge, settle outputs
  task automatic step(input bit v, input int d, input bit rdy, input bit rst);
    bit pop, keep, s;
    int val;
    @(negedge clk);
    Reset = rst; In_Valid = v; In_Data = d[IN_W-1:0]; Out_Ready = rdy;
    @(posedge clk);
    if (rst) begin
      m_warm = 0; m_phase = 0; m_sat = 1'b0; m_ovf = 1'b0; mq.delete();
    end else begin
      pop = (mq.size() != 0) && rdy;
      keep = 1'b0;
      if (v) begin
        if (m_warm < WARMUP) m_warm++;
        else begin
          keep = (m_phase == 0);
          m_phase = (m_phase + 1) % DECIM;
        end
      end
      if (pop) void'(mq.pop_front());
      if (keep) begin
        val = ref_round(d, s);
        if (s) m_sat = 1'b1;
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(val);
      end
    end
    #1;
  endtask

  task automatic do_warmup();
    for (int i = 0; i < WARMUP; i++) step(1'b1, rand_sample(), 1'b1, 1'b0);
  endtask

  task automatic fillers(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 999, rdy, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    tests_run++;
    if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", Out_Valid); end
    tests_run++;
    if (Out_Data !== 16'd0) begin tests_failed++; $display("FAIL reset_data: got %0h expected 0", Out_Data); end
    tests_run++;
    if (Count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", Count); end
    tests_run++;
    if (Sat_Flag !== 1'b0 || Overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got sat=%0b ovf=%0b expected 0 0", Sat_Flag, Overflow);
    end
  endtask

  task automatic test_warmup();
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < WARMUP; i++) begin
      step(1'b1, 100, 1'b1, 1'b0);
      tests_run++;
      if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL warmup_discard[%0d]: got valid=%0b expected 0", i, Out_Valid); end
    end
    step(1'b1, 40, 1'b1, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'd5) begin
      tests_failed++; $display("FAIL warmup_first: got valid=%0b data=%0d expected 1 5", Out_Valid, $signed(Out_Data));
    end
  endtask

  task automatic test_decimation();
    int seq[13] = '{8, 999, 999, 999, 12, 999, 999, 999, -12, 999, 999, 999, -13};
    int exp_out[4] = '{1, 2, -1, -2};
    int got[$];
    step(1'b0, 0, 1'b1, 1'b1);
    do_warmup();
    for (int i = 0; i < 13; i++) begin
      step(1'b1, seq[i], 1'b1, 1'b0);
      if (Out_Valid) got.push_back(int'($signed(Out_Data)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step(1'b0, 999, 1'b1, 1'b0);
        if (Out_Valid) got.push_back(int'($signed(Out_Data)));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      if (Out_Valid) got.push_back(int'($signed(Out_Data)));
    end
    tests_run++;
    if (got.size() != 4) begin tests_failed++; $display("FAIL decim_count: got %0d outputs expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      tests_run++;
      if (got[i] != exp_out[i]) begin tests_failed++; $display("FAIL decim_out[%0d]: got %0d expected %0d", i, got[i], exp_out[i]); end
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 0, 1'b1, 1'b1);
    do_warmup();
    tests_run++;
    if (Sat_Flag !== 1'b0) begin tests_failed++; $display("FAIL sat_pre: got %0b expected 0", Sat_Flag); end
    step(1'b1, 262143, 1'b1, 1'b0);
    tests_run++;
    if (Out_Data !== 16'h7fff || Sat_Flag !== 1'b1) begin
      tests_failed++; $display("FAIL sat_pos: got data=%0h sat=%0b expected 7fff 1", Out_Data, Sat_Flag);
    end
    fillers(3, 1'b1);
    step(1'b1, -262144, 1'b1, 1'b0);
    tests_run++;
    if (Out_Data !== 16'h8000 || Sat_Flag !== 1'b1) begin
      tests_failed++; $display("FAIL sat_neg: got data=%0h sat=%0b expected 8000 1", Out_Data, Sat_Flag);
    end
  endtask

  task automatic test_backpressure();
    step(1'b0, 0, 1'b0, 1'b1);
    do_warmup();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 8 * k, 1'b0, 1'b0);
      fillers(3, 1'b0);
    end
    tests_run++;
    if (Count !== 3'd4 || Overflow !== 1'b1) begin
      tests_failed++; $display("FAIL bp_full: got count=%0d ovf=%0b expected 4 1", Count, Overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      tests_run++;
      if (Out_Valid !== 1'b1 || Out_Data !== 16'(k)) begin
        tests_failed++; $display("FAIL bp_drain[%0d]: got valid=%0b data=%0d expected 1 %0d", k, Out_Valid, $signed(Out_Data), k);
      end
      step(1'b0, 0, 1'b1, 1'b0);
    end
    tests_run++;
    if (Out_Valid !== 1'b0 || Count !== 3'd0) begin
      tests_failed++; $display("FAIL bp_empty: got valid=%0b count=%0d expected 0 0", Out_Valid, Count);
    end
  endtask

  task automatic test_full_pushpop();
    int exp_out[4] = '{2, 3, 4, 10};
    step(1'b0, 0, 1'b0, 1'b1);
    do_warmup();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8 * k, 1'b0, 1'b0);
      fillers(3, 1'b0);
    end
    step(1'b1, 80, 1'b1, 1'b0);
    tests_run++;
    if (Count !== 3'd4 || Overflow !== 1'b0 || Out_Data !== 16'd2) begin
      tests_failed++; $display("FAIL pushpop_full: got count=%0d ovf=%0b head=%0d expected 4 0 2", Count, Overflow, $signed(Out_Data));
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (Out_Data !== 16'(exp_out[i])) begin
        tests_failed++; $display("FAIL pushpop_order[%0d]: got %0d expected %0d", i, $signed(Out_Data), exp_out[i]);
      end
      step(1'b0, 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 0, 1'b0, 1'b1);
    do_warmup();
    step(1'b1, 262143, 1'b0, 1'b0);
    fillers(3, 1'b0);
    step(1'b1, 16, 1'b0, 1'b0);
    fillers(3, 1'b0);
    step(1'b1, 24, 1'b0, 1'b0);
    tests_run++;
    if (Count !== 3'd3 || Sat_Flag !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre: got count=%0d sat=%0b expected 3 1", Count, Sat_Flag);
    end
    step(1'b1, 8, 1'b1, 1'b1);
    tests_run++;
    if (Count !== 3'd0 || Sat_Flag !== 1'b0 || Overflow !== 1'b0 || Out_Valid !== 1'b0 || Out_Data !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got count=%0d sat=%0b ovf=%0b valid=%0b data=%0h expected all 0",
               Count, Sat_Flag, Overflow, Out_Valid, Out_Data);
    end
    for (int i = 0; i < WARMUP; i++) begin
      step(1'b1, rand_sample(), 1'b1, 1'b0);
      tests_run++;
      if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rewarm[%0d]: got valid=%0b expected 0", i, Out_Valid); end
    end
    step(1'b1, 40, 1'b1, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'd5) begin
      tests_failed++; $display("FAIL mid_first: got valid=%0b data=%0d expected 1 5", Out_Valid, $signed(Out_Data));
    end
  endtask

  task automatic test_random();
    bit v, rdy, rst;
    step(1'b0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = (c < 1500) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 399) == 0);
      step(v, rand_sample(), rdy, rst);
      tests_run++;
      if (Out_Valid !== (mq.size() != 0)) begin
        tests_failed++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, Out_Valid, mq.size() != 0);
      end
      tests_run++;
      if (Count !== 3'(mq.size())) begin
        tests_failed++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, Count, mq.size());
      end
      tests_run++;
      if (Sat_Flag !== m_sat || Overflow !== m_ovf) begin
        tests_failed++; $display("FAIL rnd_flags@%0d: got sat=%0b ovf=%0b expected %0b %0b", c, Sat_Flag, Overflow, m_sat, m_ovf);
      end
      if (mq.size() != 0) begin
        tests_run++;
        if (Out_Data !== 16'(mq[0])) begin
          tests_failed++; $display("FAIL rnd_data@%0d: got %0d expected %0d", c, $signed(Out_Data), mq[0]);
        end
      end
    end
  endtask

  initial begin
    m_warm = 0; m_phase = 0; m_sat = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_warmup();
    test_decimation();
    test_saturation();
    test_backpressure();
    test_full_pushpop();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
